// File: rtl/cpx_arb_pkg.sv
// Shared types, defaults and helpers for the CPX per-destination arbiter.
package cpx_arb_pkg;

  localparam int CPX_NUM_SRC  = 8;
  localparam int CPX_QDEPTH   = 2;
  localparam int CPX_LOCK_TMO = 16;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // First set bit of vec[n-1:0] at or after ptr, wrapping; -1 when none set.
  function automatic int rr_first(input logic [31:0] vec, input int ptr, input int n);
    int idx;
    int res;
    res = -1;
    for (int k = 0; k < 32; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && res < 0 && vec[idx[4:0]]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/cpx_arb_srcq.sv
// Per-source request queue: QDEPTH-entry FIFO of atom bits with occupancy count.
module cpx_arb_srcq
  import cpx_arb_pkg::*;
#(
  parameter int QDEPTH = CPX_QDEPTH
) (
  input  logic rclk,
  input  logic reset,
  input  logic enq,
  input  logic enq_atom,
  input  logic deq,
  output logic head_atom,
  output logic tail_atom,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [QDEPTH-1:0] atom_q, atom_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  assign full      = (cnt_q == CW'(QDEPTH));
  assign empty     = (cnt_q == '0);
  assign head_atom = atom_q[0];

  always_comb begin
    tail_atom = 1'b0;
    for (int i = 0; i < QDEPTH; i++)
      if (cnt_q == CW'(i + 1)) tail_atom = atom_q[i];
  end

  // Head sits at index 0; a same-cycle dequeue shifts first so the new entry lands behind the survivors.
  always_comb begin
    atom_d = atom_q;
    cnt_d  = cnt_q;
    if (deq && !empty) begin
      atom_d = atom_q >> 1;
      cnt_d  = cnt_q - CW'(1);
    end
    if (enq && !full) begin
      for (int i = 0; i < QDEPTH; i++)
        if (cnt_d == CW'(i)) atom_d[i] = enq_atom;
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      atom_q <= '0;
      cnt_q  <= '0;
    end else begin
      atom_q <= atom_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cpx_arb_ctl.sv
// CPX per-destination round-robin arbiter with atomic-pair locking.
// Optional protocol checker on cpx_arb_err enabled by CPX_ARB_ERR_CHK_EN.
module cpx_arb_ctl
  import cpx_arb_pkg::*;
#(
  parameter int NUM_SRC = CPX_NUM_SRC,
  parameter int QDEPTH  = CPX_QDEPTH
) (
  input  logic               rclk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] scache_cpx_req_cq,
  input  logic [NUM_SRC-1:0] scache_cpx_atom_cq,
  input  logic               cpx_dest_stall_ca,
  output logic [NUM_SRC-1:0] cpx_scache_grant_ca,
  output logic [NUM_SRC-1:0] cpx_arb_sel_cx,
  output logic               cpx_arb_err
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] empty, full, head_atom, tail_atom;
  logic [NUM_SRC-1:0] grant_d, grant_q, sel_q;
  arb_state_e         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, lock_src_q, lock_src_d, pick;
  logic               pick_vld;
  int                 found;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_srcq
    cpx_arb_srcq #(.QDEPTH(QDEPTH)) u_srcq (
      .rclk      (rclk),
      .reset     (reset),
      .enq       (scache_cpx_req_cq[g]),
      .enq_atom  (scache_cpx_atom_cq[g]),
      .deq       (grant_d[g]),
      .head_atom (head_atom[g]),
      .tail_atom (tail_atom[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // Decisions use queue contents from before this edge, so a req is never granted in its own cycle.
  always_comb begin
    found      = rr_first(32'(~empty), int'(ptr_q), NUM_SRC);
    pick       = '0;
    pick_vld   = 1'b0;
    grant_d    = '0;
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_src_d = lock_src_q;
    if (!cpx_dest_stall_ca) begin
      if (state_q == ST_LOCK) begin
        if (!empty[lock_src_q]) begin
          pick_vld = 1'b1;
          pick     = lock_src_q;
        end
      end else if (found >= 0) begin
        pick_vld = 1'b1;
        pick     = PW'(found);
      end
    end
    if (pick_vld) begin
      grant_d[pick] = 1'b1;
      if (state_q == ST_LOCK) begin
        state_d = ST_ARB;
        ptr_d   = (pick == PW'(NUM_SRC - 1)) ? '0 : pick + PW'(1);
      end else if (head_atom[pick]) begin
        state_d    = ST_LOCK;
        lock_src_d = pick;
      end else begin
        ptr_d = (pick == PW'(NUM_SRC - 1)) ? '0 : pick + PW'(1);
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      lock_src_q <= '0;
      grant_q    <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_src_q <= lock_src_d;
      grant_q    <= grant_d;
      sel_q      <= grant_q;
    end
  end

  assign cpx_scache_grant_ca = grant_q;
  assign cpx_arb_sel_cx      = sel_q;

`ifdef CPX_ARB_ERR_CHK_EN
  logic       err_q, err_d, tmo_hit;
  logic [4:0] tmo_cnt_q, tmo_cnt_d;

  // Stalled cycles freeze the starvation timer rather than restarting it.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = 1'b0;
    if (state_q == ST_LOCK && empty[lock_src_q]) begin
      if (!cpx_dest_stall_ca) begin
        if (tmo_cnt_q == '0) tmo_hit = 1'b1;
        else tmo_cnt_d = tmo_cnt_q - 5'd1;
      end
    end else begin
      tmo_cnt_d = 5'(CPX_LOCK_TMO);
    end
    err_d = err_q | tmo_hit | (|(scache_cpx_req_cq & full))
          | (|(scache_cpx_req_cq & scache_cpx_atom_cq & tail_atom));
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      err_q     <= 1'b0;
      tmo_cnt_q <= 5'(CPX_LOCK_TMO);
    end else begin
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign cpx_arb_err = err_q;
`else
  logic unused_chk;
  assign unused_chk  = ^{tail_atom, full};
  assign cpx_arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpx_arb_ctl.sv
// Directed self-checking bench for cpx_arb_ctl.
module tb_cpx_arb_ctl;

  logic       rclk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] atom;
  logic       stall;
  logic [7:0] grant;
  logic [7:0] sel;
  logic       err;

  int checks = 0;
  int errors = 0;

`ifdef CPX_ARB_ERR_CHK_EN
  localparam logic EXP_OVF_ERR = 1'b1;
`else
  localparam logic EXP_OVF_ERR = 1'b0;
`endif

  cpx_arb_ctl dut (
    .rclk                (rclk),
    .reset               (reset),
    .scache_cpx_req_cq   (req),
    .scache_cpx_atom_cq  (atom),
    .cpx_dest_stall_ca   (stall),
    .cpx_scache_grant_ca (grant),
    .cpx_arb_sel_cx      (sel),
    .cpx_arb_err         (err)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    atom  = '0;
    stall = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    chk("rst_grant", grant, 8'h00);
    chk("rst_sel", sel, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);

    // single request, latency through grant and sel
    req = 8'h08; step(); req = 8'h00;
    chk("own_cycle", grant, 8'h00);
    step();
    chk("single_grant", grant, 8'h08);
    chk("single_sel0", sel, 8'h00);
    step();
    chk("single_grant_off", grant, 8'h00);
    chk("single_sel", sel, 8'h08);

    reset = 1'b1; step(); reset = 1'b0;

    // all sources at once, round robin from 0
    req = 8'hFF; step(); req = 8'h00;
    chk("ff_own_cycle", grant, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_grant%0d", i), grant, 8'(1 << i));
      if (i > 0) chk($sformatf("rr_sel%0d", i), sel, 8'(1 << (i - 1)));
    end
    req = 8'h81; step(); req = 8'h00;
    chk("wrap_idle", grant, 8'h00);
    step();
    chk("wrap_first", grant, 8'h01);
    step();
    chk("wrap_second", grant, 8'h80);
    step();
    chk("wrap_done", grant, 8'h00);

    // atomic pair on source 2 with source 5 competing
    req = 8'h24; atom = 8'h04; step(); req = 8'h00; atom = 8'h00;
    step();
    chk("atom_first", grant, 8'h04);
    req = 8'h04; step(); req = 8'h00;
    chk("atom_wait", grant, 8'h00);
    step();
    chk("atom_second", grant, 8'h04);
    step();
    chk("atom_other", grant, 8'h20);
    step();
    chk("atom_idle", grant, 8'h00);

    // stall with a plain request queued
    req = 8'h02; stall = 1'b1; step(); req = 8'h00;
    chk("stall_c1", grant, 8'h00);
    step();
    chk("stall_c2", grant, 8'h00);
    step();
    chk("stall_c3", grant, 8'h00);
    stall = 1'b0; step();
    chk("stall_release", grant, 8'h02);

    // stall in the middle of a locked pair on source 3, source 4 waiting
    req = 8'h18; atom = 8'h08; step();
    req = 8'h08; atom = 8'h00; step(); req = 8'h00;
    chk("lk_first", grant, 8'h08);
    stall = 1'b1; step();
    chk("lk_stall1", grant, 8'h00);
    step();
    chk("lk_stall2", grant, 8'h00);
    stall = 1'b0; step();
    chk("lk_second", grant, 8'h08);
    step();
    chk("lk_other", grant, 8'h10);
    step();
    chk("lk_idle", grant, 8'h00);
    chk("err_clean", {7'b0, err}, 8'h00);

    // overflow source 6 while stalled
    stall = 1'b1;
    req = 8'h40; step(); step(); step(); req = 8'h00;
    step();
    chk("ovf_grant_stalled", grant, 8'h00);
    chk("ovf_err", {7'b0, err}, {7'b0, EXP_OVF_ERR});
    stall = 1'b0; step();
    chk("ovf_g1", grant, 8'h40);
    step();
    chk("ovf_g2", grant, 8'h40);
    step();
    chk("ovf_g3", grant, 8'h00);
    step();
    chk("ovf_g4", grant, 8'h00);
    chk("ovf_err_sticky", {7'b0, err}, {7'b0, EXP_OVF_ERR});

    // reset in the middle of a locked pair, with source 1 also queued
    req = 8'h03; atom = 8'h01; step(); req = 8'h00; atom = 8'h00;
    step();
    chk("mid_first", grant, 8'h01);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_grant", grant, 8'h00);
    chk("mid_rst_sel", sel, 8'h00);
    chk("mid_rst_err", {7'b0, err}, 8'h00);
    step();
    chk("mid_q_empty1", grant, 8'h00);
    step();
    chk("mid_q_empty2", grant, 8'h00);
    req = 8'h10; step(); req = 8'h00;
    step();
    chk("fresh_grant", grant, 8'h10);
    step();
    chk("fresh_sel", sel, 8'h10);
    chk("fresh_done", grant, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
